i_cache: RTL and testbench

I_CACHE -- requirements
Module: i_cache

---
 rtl/i_cache.sv | 135 +++++++++++++
 tb/tb_i_cache.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i_cache.sv
// rtl/i_cache.sv - direct-mapped instruction cache with line fill from memory
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_readM, i_address        CPU fetch request and word address
//   i_data, i_ready           fetched word, valid in the same cycle as a hit
//   mem_readM, mem_address    line-fill read request and word address
//   mem_data, mem_valid       fill word from memory and its strobe
//   flush                     invalidate every line, aborts a fill in progress
//   hit_count, miss_count     wrapping fetch hit / miss counters
module i_cache #(
  parameter int WORD_SIZE  = 16,
  parameter int LINES      = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_readM,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  output logic                 mem_readM,
  output logic [WORD_SIZE-1:0] mem_address,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 mem_valid,
  input  logic                 flush,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state;
  logic [LINES-1:0]     valid;
  logic [TAG_W-1:0]     tag_mem  [LINES];
  logic [WORD_SIZE-1:0] data_mem [LINES*LINE_WORDS];

  logic [TAG_W-1:0]     fill_tag;
  logic [IDX_W-1:0]     fill_idx;
  logic [OFF_W-1:0]     fill_cnt;

  logic [TAG_W-1:0]     req_tag;
  logic [IDX_W-1:0]     req_idx;
  logic [OFF_W-1:0]     req_off;
  logic                 hit;
  logic                 fill_last;
  logic                 fill_we;

  assign req_tag = i_address[WORD_SIZE-1 -: TAG_W];
  assign req_idx = i_address[OFF_W +: IDX_W];
  assign req_off = i_address[OFF_W-1:0];

  // Hits are only reported from IDLE, so a line being filled can never hit
  // early even though its tag may already match.
  assign hit = (state == IDLE) && i_readM && valid[req_idx] &&
               (tag_mem[req_idx] == req_tag);

  assign fill_last = (fill_cnt == OFF_W'(LINE_WORDS - 1));
  assign fill_we   = (state == FILL) && mem_valid && !flush;

  always_comb begin
    i_ready     = hit;
    i_data      = '0;
    mem_readM   = 1'b0;
    mem_address = '0;
    if (hit) begin
      i_data = data_mem[{req_idx, req_off}];
    end
    if (state == FILL) begin
      mem_readM   = 1'b1;
      mem_address = {fill_tag, fill_idx, fill_cnt};
    end
  end

  // Tag and data storage: no reset, validity is carried by the valid bits.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_mem[{fill_idx, fill_cnt}] <= mem_data;
      if (fill_last) begin
        tag_mem[fill_idx] <= fill_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      valid      <= '0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      fill_cnt   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit) begin
        hit_count <= hit_count + 16'd1;
      end
      // flush wins over both a pending miss and an active fill
      if (flush) begin
        valid    <= '0;
        state    <= IDLE;
        fill_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (i_readM && !hit) begin
              fill_tag   <= req_tag;
              fill_idx   <= req_idx;
              fill_cnt   <= '0;
              miss_count <= miss_count + 16'd1;
              state      <= FILL;
            end
          end
          FILL: begin
            if (mem_valid) begin
              if (fill_last) begin
                valid[fill_idx] <= 1'b1;
                fill_cnt        <= '0;
                state           <= IDLE;
              end else begin
                fill_cnt <= fill_cnt + OFF_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i_cache.sv
// tb/tb_i_cache.sv - directed scoreboard bench for i_cache
module tb_i_cache;

  logic        clk;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_ready;
  logic        mem_readM;
  logic [15:0] mem_address;
  logic [15:0] mem_data;
  logic        mem_valid;
  logic        flush;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [15:0] exp_q[$];

  i_cache #(.WORD_SIZE(16), .LINES(8), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_readM    (i_readM),
    .i_address  (i_address),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .mem_readM  (mem_readM),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_valid  (mem_valid),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  // memory model: every word holds its own address
  assign mem_data = mem_address;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every i_ready must correspond to a queued expected word
  always @(negedge clk) begin
    if (reset_n && i_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 16'(i_ready), 16'h0000);
      end else begin
        check("sb_i_data", i_data, exp_q.pop_front());
      end
    end
  end

  // Miss on addr, fill the line (optionally stalling 3 cycles before
  // stall_word), then refetch addr and expect the hit.
  task automatic do_miss(input logic [15:0] addr, input int stall_word);
    logic [15:0] base;
    base      = {addr[15:2], 2'b00};
    i_readM   = 1'b1;
    i_address = addr;
    mem_valid = 1'b1;
    @(negedge clk);
    check("miss_ready", 16'(i_ready), 16'h0000);
    check("miss_data", i_data, 16'h0000);
    check("miss_idle_mem_addr", mem_address, 16'h0000);
    next_cycle();
    exp_misses++;
    // request dropped and address changed mid-fill: must be ignored
    i_readM   = 1'b0;
    i_address = 16'hFFFF;
    for (int w = 0; w < 4; w++) begin
      if (w == stall_word) begin
        for (int s = 0; s < 3; s++) begin
          mem_valid = 1'b0;
          i_readM   = 1'b1;
          @(negedge clk);
          check("stall_mem_addr", mem_address, base + 16'(w));
          check("stall_ready", 16'(i_ready), 16'h0000);
          next_cycle();
          i_readM = 1'b0;
        end
      end
      mem_valid = 1'b1;
      @(negedge clk);
      check("fill_readM", 16'(mem_readM), 16'h0001);
      check("fill_mem_addr", mem_address, base + 16'(w));
      check("fill_ready", 16'(i_ready), 16'h0000);
      next_cycle();
    end
    mem_valid = 1'b0;
    i_readM   = 1'b1;
    i_address = addr;
    exp_q.push_back(addr);
    @(negedge clk);
    check("refetch_ready", 16'(i_ready), 16'h0001);
    check("refetch_readM", 16'(mem_readM), 16'h0000);
    check("miss_count", miss_count, 16'(exp_misses));
    next_cycle();
    exp_hits++;
    i_readM = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    i_readM   = 1'b0;
    i_address = 16'h0000;
    mem_valid = 1'b0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_ready", 16'(i_ready), 16'h0000);
    check("rst_readM", 16'(mem_readM), 16'h0000);
    check("rst_mem_addr", mem_address, 16'h0000);
    check("rst_hits", hit_count, 16'h0000);
    check("rst_misses", miss_count, 16'h0000);
    next_cycle();
    reset_n = 1'b1;
    next_cycle();

    // cold miss: 0x0012, fill 0x0010..0x0013, hit in cycle 5
    do_miss(16'h0012, 4);

    // three hits in the same line on consecutive cycles
    begin
      logic [15:0] hit_addrs [3];
      hit_addrs[0] = 16'h0010;
      hit_addrs[1] = 16'h0011;
      hit_addrs[2] = 16'h0013;
      for (int i = 0; i < 3; i++) begin
        i_readM   = 1'b1;
        i_address = hit_addrs[i];
        exp_q.push_back(hit_addrs[i]);
        @(negedge clk);
        check("same_line_ready", 16'(i_ready), 16'h0001);
        next_cycle();
        exp_hits++;
      end
      i_readM = 1'b0;
    end
    @(negedge clk);
    check("hit_count_4", hit_count, 16'(exp_hits));

    // conflict: 0x0032 evicts line 4, then 0x0012 misses again, stalled
    next_cycle();
    do_miss(16'h0032, 4);
    do_miss(16'h0012, 1);
    check("conflict_miss_count", miss_count, 16'h0003);

    // flush after word 2 of a fill
    i_readM   = 1'b1;
    i_address = 16'h0052;
    mem_valid = 1'b1;
    next_cycle();
    exp_misses++;
    i_readM = 1'b0;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      check("pre_flush_addr", mem_address, 16'h0050 + 16'(w));
      next_cycle();
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_addr", mem_address, 16'h0053);
    next_cycle();
    flush     = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    check("post_flush_readM", 16'(mem_readM), 16'h0000);
    check("post_flush_addr", mem_address, 16'h0000);
    next_cycle();

    // flush beats a simultaneous miss
    flush     = 1'b1;
    i_readM   = 1'b1;
    i_address = 16'h0052;
    @(negedge clk);
    check("flush_miss_ready", 16'(i_ready), 16'h0000);
    next_cycle();
    flush   = 1'b0;
    i_readM = 1'b0;
    @(negedge clk);
    check("flush_prio_readM", 16'(mem_readM), 16'h0000);
    check("flush_prio_misses", miss_count, 16'(exp_misses));
    next_cycle();

    // refetch after flush restarts a full fill at offset 0
    do_miss(16'h0052, 4);

    // reset during a fill
    i_readM   = 1'b1;
    i_address = 16'h0072;
    mem_valid = 1'b1;
    next_cycle();
    i_readM = 1'b0;
    @(negedge clk);
    check("pre_rst_addr", mem_address, 16'h0070);
    next_cycle();
    reset_n = 1'b0;
    #1;
    check("midrst_ready", 16'(i_ready), 16'h0000);
    check("midrst_readM", 16'(mem_readM), 16'h0000);
    check("midrst_mem_addr", mem_address, 16'h0000);
    check("midrst_data", i_data, 16'h0000);
    check("midrst_hits", hit_count, 16'h0000);
    check("midrst_misses", miss_count, 16'h0000);
    next_cycle();
    reset_n    = 1'b1;
    mem_valid  = 1'b0;
    exp_hits   = 0;
    exp_misses = 0;
    next_cycle();
    do_miss(16'h0072, 4);
    check("final_hits", hit_count, 16'(exp_hits));

    check("sb_drained", 16'(exp_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
